// File: rtl/conv_result_collector.sv
// conv_result_collector: catches one bank of accumulated pixels from the kernel
// array, holds it in a two-entry ping-pong store and streams it lane by lane
// to the pooling/writeback stage over a valid/ready handshake.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module conv_result_collector #(
  parameter int ARRAY_SIZE = 6,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] i_pixel_bus,
  input  logic                             i_capture,
  input  logic                             i_ready,
  input  logic                             i_clear_ovf,
  output logic [DATA_WIDTH-1:0]            o_pixel,
  output logic [$clog2(ARRAY_SIZE)-1:0]    o_lane,
  output logic                             o_valid,
  output logic                             o_last,
  output logic                             o_array_clear,
  output logic                             o_full,
  output logic                             o_overflow
);

  localparam int LW    = $clog2(ARRAY_SIZE);
  localparam int BUS_W = ARRAY_SIZE * DATA_WIDTH;
  localparam logic [LW-1:0] LAST_LANE = LW'(ARRAY_SIZE - 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [1:0]      occ_q, occ_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic            ovf_q, ovf_d;
  logic            clear_q, clear_d;

  logic [BUS_W-1:0]      entry_q [2];
  logic [DATA_WIDTH-1:0] lane_pix [ARRAY_SIZE];

  logic transfer;
  logic last_xfer;
  logic accept;
  logic drop;

  // A beat moves whenever we are presenting and downstream takes it.
  assign transfer  = (state_q == STREAM) && i_ready;
  assign last_xfer = transfer && (lane_q == LAST_LANE);
  // A full store can still take a capture if the read entry drains this cycle;
  // in that case the write pointer equals the read pointer and the slot is reused.
  assign accept    = i_capture && (!(occ_q[0] && occ_q[1]) || last_xfer);
  assign drop      = i_capture && !accept;

  // Unpack the current read entry into lanes; lane 0 is the MSB slice of the bus.
  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
    assign lane_pix[gi] = entry_q[rd_ptr_q][(ARRAY_SIZE-gi)*DATA_WIDTH-1 -: DATA_WIDTH];
  end

  // Next-state logic: occupancy, pointers, lane counter, overflow and FSM.
  always_comb begin
    state_d  = state_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lane_d   = lane_q;
    ovf_d    = ovf_q;
    clear_d  = accept;

    if (transfer) begin
      if (last_xfer) begin
        lane_d          = '0;
        occ_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = ~rd_ptr_q;
      end else begin
        lane_d = lane_q + LW'(1);
      end
    end

    // Applied after the pop so a reused slot ends up occupied.
    if (accept) begin
      occ_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = ~wr_ptr_q;
    end

    // A drop in the same cycle as a clear request keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (i_clear_ovf) begin
      ovf_d = 1'b0;
    end

    unique case (state_q)
      IDLE:   if (|occ_d) state_d = STREAM;
      STREAM: if (last_xfer && !(|occ_d)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers with asynchronous reset; an in-flight bank is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      occ_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      lane_q   <= '0;
      ovf_q    <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lane_q   <= lane_d;
      ovf_q    <= ovf_d;
      clear_q  <= clear_d;
    end
  end

  // Bank storage: written only on an accepted capture; contents are qualified
  // by the occupancy bits, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      entry_q[wr_ptr_q] <= i_pixel_bus;
    end
  end

  // Outputs come only from registered state, so they hold under backpressure.
  assign o_valid       = (state_q == STREAM);
  assign o_pixel       = o_valid ? lane_pix[lane_q] : '0;
  assign o_lane        = o_valid ? lane_q : '0;
  assign o_last        = o_valid && (lane_q == LAST_LANE);
  assign o_array_clear = clear_q;
  assign o_full        = occ_q[0] && occ_q[1];
  assign o_overflow    = ovf_q;

endmodule
